// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer that shares the cache_ctrl user port between two
// single-word requesters, generating one-cycle strobes and returning data with an ack.
module mem_port_arbiter #(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic                m0_write,
  input  logic [W_ADDR-1:0]   m0_addr,
  input  logic [W_DATA-1:0]   m0_wdata,
  input  logic [W_DATA/8-1:0] m0_mask,
  output logic                m0_ack,
  output logic [W_DATA-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_write,
  input  logic [W_ADDR-1:0]   m1_addr,
  input  logic [W_DATA-1:0]   m1_wdata,
  input  logic [W_DATA/8-1:0] m1_mask,
  output logic                m1_ack,
  output logic [W_DATA-1:0]   m1_rdata,
  output logic                mem_rd_en,
  output logic                mem_wr_en,
  output logic [W_ADDR-1:0]   mem_addr,
  output logic [W_DATA-1:0]   mem_wdata,
  output logic [W_DATA/8-1:0] mem_mask,
  input  logic [W_DATA-1:0]   mem_rdata,
  input  logic                mem_busy,
  output logic                owner,
  output logic                timeout_err
);

  localparam int W_MASK = W_DATA / 8;
  localparam int W_CNT  = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [W_CNT-1:0]  CNT_LAST  = W_CNT'(BUSY_TIMEOUT - 1);
  localparam logic [W_ADDR-1:0] ADDR_MASK = {{(W_ADDR-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              write_q, write_d;
  logic [W_ADDR-1:0] addr_q, addr_d;
  logic [W_DATA-1:0] wdata_q, wdata_d;
  logic [W_MASK-1:0] mask_q, mask_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [W_DATA-1:0] m0_rdata_q, m0_rdata_d;
  logic [W_DATA-1:0] m1_rdata_q, m1_rdata_d;
  logic              timeout_q, timeout_d;
  logic [W_CNT-1:0]  cnt_q, cnt_d;
  logic              grant;
  logic              finish;

  // owner_q doubles as last_grant: on contention the requester not served last wins.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;
    grant      = 1'b0;
    finish     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!mem_busy && (m0_req || m1_req)) begin
          grant   = (m0_req && m1_req) ? ~owner_q : m1_req;
          owner_d = grant;
          write_d = grant ? m1_write : m0_write;
          addr_d  = (grant ? m1_addr : m0_addr) & ADDR_MASK;
          wdata_d = grant ? m1_wdata : m0_wdata;
          mask_d  = grant ? m1_mask : m0_mask;
          rd_en_d = ~write_d;
          wr_en_d = write_d;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (mem_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          finish    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!mem_busy) begin
          finish = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Normal completion and busy timeout share the response path; writes leave rdata alone.
    if (finish) begin
      state_d  = RESP;
      m0_ack_d = ~owner_q;
      m1_ack_d = owner_q;
      if (!write_q) begin
        if (owner_q) begin
          m1_rdata_d = mem_rdata;
        end else begin
          m0_rdata_d = mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b1;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_mask    = mask_q;
  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: randomized requesters, a cache_ctrl model with
// configurable busy timing, and a monitor checking grants, strobes, latency and acks.
module tb_mem_port_arbiter;

  localparam int BUSY_TIMEOUT = 16;

  typedef struct {
    int ack_cyc;
    bit to;
  } lat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  mask  [2];
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;
  logic        mem_busy, owner, timeout_err;
  logic        busy_force = 1'b0;
  logic        busy_gen;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int strobe_cnt = 0;

  bit cfg_rand = 1'b0;
  bit cfg_nb   = 1'b0;
  int cfg_d1   = 1;
  int cfg_n    = 2;

  logic [31:0] cache_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] last_rd   [2];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          grant_q [$];
  lat_t        lat_q [$];
  int          owner_hist [$];
  logic        snap0, snap1;
  logic        model_last = 1'b1;

  assign mem_busy = busy_force | busy_gen;

  always #5 clk = ~clk;

  mem_port_arbiter #(.W_ADDR(32), .W_DATA(32), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_write(wr[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_mask(mask[0]), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_write(wr[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_mask(mask[1]), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
    .mem_busy(mem_busy), .owner(owner), .timeout_err(timeout_err)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] mk);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (mk[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] cm_read(input logic [31:0] a);
    return cache_mem.exists(a) ? cache_mem[a] : init_word(a);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    snap0 = req[0];
    snap1 = req[1];
  end

  // cache_ctrl model: busy rises d1 cycles after the strobe cycle and stays high n cycles;
  // read data only becomes valid when busy falls (or immediately when busy never rises).
  initial begin : cache_model
    int   wait_cnt, left, d1, n;
    bit   active, rd, nb;
    logic [31:0] a, ca;
    lat_t l;
    busy_gen  = 1'b0;
    mem_rdata = '0;
    active    = 1'b0;
    rd        = 1'b0;
    ca        = '0;
    wait_cnt  = 0;
    left      = 0;
    cache_mem[32'h0000_1000] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_gen = 1'b0;
        active   = 1'b0;
      end else if (mem_rd_en || mem_wr_en) begin
        strobe_cnt++;
        a = mem_addr;
        if (mem_wr_en) cache_mem[a] = merge(cm_read(a), mem_wdata, mem_mask);
        rd = mem_rd_en;
        ca = a;
        if (cfg_rand) begin
          nb = ($urandom_range(0, 9) == 0);
          d1 = $urandom_range(1, 4);
          n  = $urandom_range(1, 5);
        end else begin
          nb = cfg_nb;
          d1 = cfg_d1;
          n  = cfg_n;
        end
        if (nb) begin
          mem_rdata = rd ? cm_read(a) : $urandom;
          l.ack_cyc = cyc + BUSY_TIMEOUT + 1;
          l.to      = 1'b1;
        end else begin
          mem_rdata = $urandom;
          wait_cnt  = d1;
          left      = n;
          active    = 1'b1;
          l.ack_cyc = cyc + d1 + n + 1;
          l.to      = 1'b0;
        end
        lat_q.push_back(l);
      end else if (active) begin
        if (!busy_gen) begin
          if (wait_cnt > 1) wait_cnt--;
          else busy_gen = 1'b1;
        end else begin
          left--;
          if (left == 0) begin
            busy_gen = 1'b0;
            active   = 1'b0;
            if (rd) mem_rdata = cm_read(ca);
          end
        end
      end
    end
  end

  // Monitor: grant decisions follow the round-robin rule on the requests seen at the
  // grant edge; every ack is matched against the scoreboard queues.
  always @(negedge clk) begin : monitor
    int   g, ai;
    lat_t lr;
    if (!rst_n) begin
      model_last = 1'b1;
      grant_q.delete();
      lat_q.delete();
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (mem_rd_en || mem_wr_en) begin
        checkOutput("strobe_exclusive", mem_rd_en & mem_wr_en, 1'b0);
        if (!(snap0 || snap1)) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL grant_without_req: strobe 0x%0h seen, no strobe required",
                   {mem_wr_en, mem_rd_en});
        end else begin
          g = (snap0 && snap1) ? int'(!model_last) : int'(snap1);
          model_last = g[0];
          checkOutput("grant_owner", owner, g);
          checkOutput("strobe_kind", {mem_wr_en, mem_rd_en}, wr[g] ? 2'b10 : 2'b01);
          checkOutput("mem_addr", mem_addr, {addr[g][31:2], 2'b00});
          if (wr[g]) begin
            checkOutput("mem_wdata", mem_wdata, wdata[g]);
            checkOutput("mem_mask", mem_mask, mask[g]);
          end
          grant_q.push_back(g);
          owner_hist.push_back(int'(owner));
        end
      end
      if (m0_ack || m1_ack) begin
        checkOutput("ack_onehot", m0_ack & m1_ack, 1'b0);
        ai = m1_ack ? 1 : 0;
        if (grant_q.size() == 0 || lat_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL ack_unexpected: m%0d_ack=1 with nothing outstanding, 0 required", ai);
        end else begin
          checkOutput("ack_owner", ai, grant_q.pop_front());
          lr = lat_q.pop_front();
          checkOutput("ack_latency_cycle", cyc, lr.ack_cyc);
          checkOutput("ack_timeout_flag", timeout_err, lr.to);
          if (ai == 0 && exp_q0.size() > 0) checkOutput("m0_rdata", m0_rdata, exp_q0.pop_front());
          else if (ai == 1 && exp_q1.size() > 0) checkOutput("m1_rdata", m1_rdata, exp_q1.pop_front());
          else begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL ack_no_expectation: m%0d ack without queued result", ai);
          end
        end
      end else if (timeout_err) begin
        checkOutput("timeout_without_ack", timeout_err, 1'b0);
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pulses"}, {mem_rd_en, mem_wr_en, m0_ack, m1_ack, timeout_err}, 5'b0);
    checkOutput({tag, "_owner"}, owner, 1'b1);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
    checkOutput({tag, "_mem_wdata_mask"}, {mem_wdata, mem_mask}, 36'h0);
    checkOutput({tag, "_rdata"}, {m0_rdata, m1_rdata}, 64'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetValues("reset");
    req[0] = 1'b0;
    req[1] = 1'b0;
    busy_force = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transaction for requester m, entered and left on a falling edge; req stays high
  // on return so the caller can chain back-to-back requests.
  task automatic applyStimulus(input int m, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] mk);
    logic [31:0] wa, e;
    int k;
    bit got;
    wa = {a[31:2], 2'b00};
    if (!w) begin
      e = ref_read(wa);
      last_rd[m] = e;
    end else begin
      ref_mem[wa] = merge(ref_read(wa), d, mk);
      e = last_rd[m];
    end
    if (m == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    wr[m] = w; addr[m] = a; wdata[m] = d; mask[m] = mk; req[m] = 1'b1;
    got = 1'b0;
    k = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      got = (m == 0) ? m0_ack : m1_ack;
    end
    if (!got) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL ack_wait_m%0d: no ack after %0d cycles, ack required", m, k);
    end
  endtask

  task automatic run_master(input int m, input int n, input int maxgap);
    int gap;
    logic [31:0] base;
    base = (m == 0) ? 32'h0000_1000 : 32'h0000_8000;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, maxgap);
      if (gap > 0) begin
        req[m] = 1'b0;
        repeat (gap) @(negedge clk);
      end
      applyStimulus(m, 1'($urandom_range(0, 1)),
                    base + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3)),
                    $urandom, 4'($urandom_range(0, 15)));
    end
    req[m] = 1'b0;
  endtask

  initial begin : main
    int s0, h0, k;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; mask[i] = '0;
      last_rd[i] = '0;
    end
    ref_mem[32'h0000_1000] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    doReset();

    // Busy held after reset: no strobe may appear until it falls.
    cfg_rand = 1'b0; cfg_nb = 1'b0; cfg_d1 = 1; cfg_n = 2;
    busy_force = 1'b1;
    s0 = strobe_cnt;
    fork
      applyStimulus(0, 1'b0, 32'h0000_1040, 32'h0, 4'h0);
      begin
        repeat (10) @(negedge clk);
        checkOutput("busy_hold_no_strobe", 32'(strobe_cnt - s0), 32'h0);
        busy_force = 1'b0;
      end
    join

    cfg_d1 = 1; cfg_n = 3;
    applyStimulus(0, 1'b0, 32'h0000_1003, 32'h0, 4'h0);
    checkOutput("m0_read_deadbeef", m0_rdata, 32'hDEADBEEF);

    cfg_n = 2;
    applyStimulus(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011);
    checkOutput("m1_write_wdata_hold", mem_wdata, 32'h1234_5678);
    checkOutput("m1_write_mask_hold", mem_mask, 4'b0011);
    checkOutput("m1_write_rdata_kept", m1_rdata, 32'h0);
    req[1] = 1'b0;

    cfg_nb = 1'b1;
    applyStimulus(0, 1'b0, 32'h0000_1080, 32'h0, 4'h0);
    req[0] = 1'b0;
    cfg_nb = 1'b0;

    // Continuous contention right after reset must alternate starting with m0.
    doReset();
    cfg_rand = 1'b1;
    h0 = owner_hist.size();
    fork
      run_master(0, 4, 0);
      run_master(1, 4, 0);
    join
    checkOutput("alt_grant_count", 32'(owner_hist.size() - h0), 32'd8);
    if (owner_hist.size() > h0) checkOutput("alt_first_owner", owner_hist[h0], 1'b0);
    for (int i = h0 + 1; i < owner_hist.size(); i++)
      checkOutput("alt_owner_toggle", owner_hist[i] ^ owner_hist[i-1], 1);

    fork
      run_master(0, 50, 3);
      run_master(1, 50, 3);
    join

    // Reset while the memory is still busy: no stale ack afterwards.
    repeat (3) @(negedge clk);
    cfg_rand = 1'b0; cfg_d1 = 1; cfg_n = 30;
    wr[1] = 1'b0; addr[1] = 32'h0000_8100; req[1] = 1'b1;
    k = 0;
    while (!mem_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("midreset_busy_seen", mem_busy, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetValues("midreset");
    req[1] = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    cfg_n = 2;
    applyStimulus(1, 1'b0, 32'h0000_8104, 32'h0, 4'h0);
    req[1] = 1'b0;

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained",
                32'(grant_q.size() + lat_q.size() + exp_q0.size() + exp_q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
